// File: rtl/axi_rd_arbiter_pkg.sv
// Shared AXI read-channel field layout and FSM encoding
// for the fetch/LSU read-port arbiter.
package axi_rd_arbiter_pkg;

    localparam int AR_W = 49;
    localparam int R_W  = 39;

    localparam int AR_BURST_LSB = 0;
    localparam int AR_SIZE_LSB  = 2;
    localparam int AR_LEN_LSB   = 5;
    localparam int AR_ID_LSB    = 13;
    localparam int AR_ADDR_LSB  = 17;

    localparam int R_ID_LSB   = 0;
    localparam int R_LAST_BIT = 4;
    localparam int R_RESP_LSB = 5;
    localparam int R_DATA_LSB = 7;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    localparam int STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    function automatic logic r_last(input logic [R_W-1:0] r);
        return r[R_LAST_BIT];
    endfunction

endpackage

// File: rtl/axi_rd_pick.sv
// Two-way read-request picker: m1 preferred, m0 forced through
// once it has watched STARVE_LIMIT consecutive m1 grants.
module axi_rd_pick #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    input  logic req0,
    input  logic req1,
    output logic gnt,
    output logic win
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] cnt;
    logic          force0;

    assign force0 = (cnt == CW'(STARVE_LIMIT));
    assign gnt    = en & (req0 | req1);
    assign win    = req1 & ~(req0 & force0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!req0) begin
            cnt <= '0;
        end else if (gnt) begin
            // win with req0 high implies the limit is not yet reached
            cnt <= win ? cnt + CW'(1) : '0;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI4 read port between fetch (m0) and LSU (m1),
// one burst at a time, with fetch-flush draining of m0 bursts.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            m0_flush_i,
    input  logic            m0_arvalid_i,
    output logic            m0_arready_o,
    input  logic [AR_W-1:0] m0_ar_i,
    output logic            m0_rvalid_o,
    input  logic            m0_rready_i,
    output logic [R_W-1:0]  m0_r_o,
    input  logic            m1_arvalid_i,
    output logic            m1_arready_o,
    input  logic [AR_W-1:0] m1_ar_i,
    output logic            m1_rvalid_o,
    input  logic            m1_rready_i,
    output logic [R_W-1:0]  m1_r_o,
    output logic            s_arvalid_o,
    input  logic            s_arready_i,
    output logic [AR_W-1:0] s_ar_o,
    input  logic            s_rvalid_i,
    output logic            s_rready_o,
    input  logic [R_W-1:0]  s_r_i,
    output logic            busy_o
);

    state_t          state;
    logic            grant;
    logic            drop;
    logic [AR_W-1:0] ar_q;

    logic idle;
    logic in_data;
    logic pick_gnt;
    logic pick_win;
    logic flush_hit;
    logic drop_eff;
    logic g_rready;
    logic beat_last;

    assign idle    = (state == ST_IDLE);
    assign in_data = (state == ST_DATA);

    axi_rd_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_pick (
        .clock (clock),
        .reset (reset),
        .en    (idle & ~reset),
        .req0  (m0_arvalid_i),
        .req1  (m1_arvalid_i),
        .gnt   (pick_gnt),
        .win   (pick_win)
    );

    // A flush only matters for an m0 burst already past IDLE
    assign flush_hit = m0_flush_i & ~grant & ~idle;
    assign drop_eff  = drop | flush_hit;
    assign g_rready  = grant ? m1_rready_i : m0_rready_i;
    assign beat_last = s_rvalid_i & s_rready_o & r_last(s_r_i);

    assign m0_arready_o = pick_gnt & ~pick_win;
    assign m1_arready_o = pick_gnt & pick_win;

    assign s_arvalid_o = (state == ST_ADDR);
    assign s_ar_o      = ar_q;
    assign s_rready_o  = in_data & (drop_eff | g_rready);
    assign busy_o      = ~idle;

    assign m0_rvalid_o = in_data & ~grant & ~drop_eff & s_rvalid_i;
    assign m1_rvalid_o = in_data & grant & s_rvalid_i;
    assign m0_r_o      = (in_data & ~grant & ~drop_eff) ? s_r_i : '0;
    assign m1_r_o      = (in_data & grant) ? s_r_i : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            grant <= 1'b0;
            drop  <= 1'b0;
            ar_q  <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    drop <= 1'b0;
                    if (pick_gnt) begin
                        grant <= pick_win;
                        ar_q  <= pick_win ? m1_ar_i : m0_ar_i;
                        state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (flush_hit) drop <= 1'b1;
                    if (s_arready_i) state <= ST_DATA;
                end
                ST_DATA: begin
                    if (flush_hit) drop <= 1'b1;
                    if (beat_last) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized bench for axi_rd_arbiter against a transaction-level
// model of grant order, starvation and flush draining.
module tb_axi_rd_arbiter;

    localparam int LIM = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        m0_flush = 1'b0;
    logic        m0_arvalid = 1'b0;
    logic        m0_arready;
    logic [48:0] m0_ar = '0;
    logic        m0_rvalid;
    logic        m0_rready = 1'b0;
    logic [38:0] m0_r;
    logic        m1_arvalid = 1'b0;
    logic        m1_arready;
    logic [48:0] m1_ar = '0;
    logic        m1_rvalid;
    logic        m1_rready = 1'b0;
    logic [38:0] m1_r;
    logic        s_arvalid;
    logic        s_arready = 1'b0;
    logic [48:0] s_ar;
    logic        s_rvalid = 1'b0;
    logic        s_rready;
    logic [38:0] s_r = '0;
    logic        busy;

    int errors = 0;
    int checks = 0;

    bit          pend0 = 0;
    bit          pend1 = 0;
    logic [48:0] pl0 = '0;
    logic [48:0] pl1 = '0;
    int          mcnt = 0;

    always #5 clock = ~clock;

    axi_rd_arbiter #(
        .STARVE_LIMIT(LIM)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .m0_flush_i   (m0_flush),
        .m0_arvalid_i (m0_arvalid),
        .m0_arready_o (m0_arready),
        .m0_ar_i      (m0_ar),
        .m0_rvalid_o  (m0_rvalid),
        .m0_rready_i  (m0_rready),
        .m0_r_o       (m0_r),
        .m1_arvalid_i (m1_arvalid),
        .m1_arready_o (m1_arready),
        .m1_ar_i      (m1_ar),
        .m1_rvalid_o  (m1_rvalid),
        .m1_rready_i  (m1_rready),
        .m1_r_o       (m1_r),
        .s_arvalid_o  (s_arvalid),
        .s_arready_i  (s_arready),
        .s_ar_o       (s_ar),
        .s_rvalid_i   (s_rvalid),
        .s_rready_o   (s_rready),
        .s_r_i        (s_r),
        .busy_o       (busy)
    );

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic logic [48:0] mk_ar(input int len);
        logic [31:0] a;
        logic [3:0]  id;
        a  = $urandom;
        id = 4'($urandom);
        return {a, id, 8'(len), 3'b010, 2'b01};
    endfunction

    // One arbitration round: add requests, predict the winner,
    // then run its address and data phases with optional flush.
    task automatic txn(input bit add0, input bit add1,
                       input int len0, input int len1,
                       input int ar_dly, input int flush_at,
                       input bit stall);
        bit          win;
        bit          flushed;
        bit          fnow;
        bit          dnow;
        bit          rv;
        bit          rr;
        bit          exp_rr;
        logic [48:0] pl;
        logic [38:0] r;
        int          beats;
        int          beat;
        int          cyc;
        if (!pend0) mcnt = 0;
        if (add0 && !pend0) begin pend0 = 1; pl0 = mk_ar(len0); end
        if (add1 && !pend1) begin pend1 = 1; pl1 = mk_ar(len1); end
        if (!pend0 && !pend1) return;
        win = pend1 && !(pend0 && mcnt == LIM);
        if (win) begin
            if (pend0) mcnt++;
        end else begin
            mcnt = 0;
        end
        m0_arvalid = pend0;
        m0_ar      = pl0;
        m1_arvalid = pend1;
        m1_ar      = pl1;
        m0_flush   = 1'($urandom);
        #1;
        chk("idle_busy", 64'(busy), 64'(0));
        chk("m0_arready", 64'(m0_arready), 64'(!win));
        chk("m1_arready", 64'(m1_arready), 64'(win));
        chk("idle_arvalid", 64'(s_arvalid), 64'(0));
        step();
        pl = win ? pl1 : pl0;
        if (win) begin pend1 = 0; m1_arvalid = 1'b0; end
        else begin pend0 = 0; m0_arvalid = 1'b0; end
        beats   = int'(pl[12:5]) + 1;
        flushed = 0;
        for (int i = 0; i <= ar_dly; i++) begin
            s_arready = (i == ar_dly);
            fnow = win ? ($urandom % 3 == 0) : (flush_at == -1 && i == 0);
            m0_flush = fnow;
            #1;
            chk("addr_arvalid", 64'(s_arvalid), 64'(1));
            chk("addr_payload", 64'(s_ar), 64'(pl));
            chk("addr_arready", 64'({m0_arready, m1_arready}), 64'(0));
            chk("addr_rready", 64'(s_rready), 64'(0));
            if (fnow && !win) flushed = 1;
            step();
        end
        s_arready = 1'b0;
        m0_flush  = 1'b0;
        beat = 0;
        cyc  = 0;
        while (beat < beats && cyc < 200) begin
            rv   = stall ? ($urandom % 3 != 0) : 1'b1;
            rr   = stall ? ($urandom % 3 != 0) : 1'b1;
            fnow = win ? ($urandom % 4 == 0) : (!flushed && flush_at == beat);
            dnow = !win && (flushed || fnow);
            r = {32'($urandom), 2'($urandom), 1'(beat == beats - 1),
                 4'($urandom)};
            s_rvalid  = rv;
            s_r       = r;
            m0_rready = win ? 1'($urandom) : rr;
            m1_rready = win ? rr : 1'($urandom);
            m0_flush  = fnow;
            #1;
            exp_rr = dnow || rr;
            chk("data_rready", 64'(s_rready), 64'(exp_rr));
            chk("m0_rvalid", 64'(m0_rvalid), 64'(!win && !dnow && rv));
            chk("m1_rvalid", 64'(m1_rvalid), 64'(win && rv));
            chk("data_busy", 64'(busy), 64'(1));
            if (win) begin
                chk("m1_r", 64'(m1_r), 64'(r));
                chk("m0_r_idle", 64'(m0_r), 64'(0));
            end else begin
                if (!dnow) chk("m0_r", 64'(m0_r), 64'(r));
                chk("m1_r_idle", 64'(m1_r), 64'(0));
            end
            if (!win && fnow) flushed = 1;
            if (rv && exp_rr) beat++;
            cyc++;
            step();
        end
        if (beat < beats) chk("beat_budget", 64'(beat), 64'(beats));
        s_rvalid  = 1'b0;
        s_r       = '0;
        m0_rready = 1'b0;
        m1_rready = 1'b0;
        m0_flush  = 1'b0;
    endtask

    initial begin
        bit a0;
        bit a1;
        int fa;
        m0_arvalid = 1'b1;
        m1_arvalid = 1'b1;
        step();
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_arvalid", 64'(s_arvalid), 64'(0));
        chk("rst_rready", 64'(s_rready), 64'(0));
        chk("rst_arready", 64'({m0_arready, m1_arready}), 64'(0));
        chk("rst_payload", 64'(s_ar), 64'(0));
        chk("rst_rvalid", 64'({m0_rvalid, m1_rvalid}), 64'(0));
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;
        step();
        reset = 1'b0;
        step();

        txn(1, 0, 3, 0, 1, -2, 0);
        txn(1, 1, 1, 1, 0, -2, 0);
        txn(0, 0, 0, 0, 0, -2, 0);
        txn(1, 1, 0, 0, 0, -2, 0);
        repeat (4) txn(0, 1, 0, 0, 0, -2, 0);
        txn(0, 0, 0, 0, 0, -2, 0);
        txn(1, 0, 3, 0, 0, 1, 0);
        txn(1, 0, 3, 0, 5, -1, 0);

        for (int n = 0; n < 250; n++) begin
            a0 = 1'($urandom);
            a1 = ($urandom % 4 != 0);
            if (!pend0 && !pend1 && !a0) a1 = 1;
            case ($urandom % 4)
                0: fa = -2;
                1: fa = -1;
                default: fa = int'($urandom % 4);
            endcase
            txn(a0, a1, int'($urandom % 4), int'($urandom % 4),
                int'($urandom % 4), fa, 1'($urandom));
        end

        for (int k = 0; k < 2; k++)
            if (pend0 || pend1) txn(0, 0, 0, 0, 0, -2, 0);

        m0_ar      = mk_ar(3);
        m0_arvalid = 1'b1;
        #1;
        chk("pre_rst_grant", 64'(m0_arready), 64'(1));
        step();
        m0_arvalid = 1'b0;
        s_arready  = 1'b1;
        step();
        s_arready  = 1'b0;
        s_rvalid   = 1'b1;
        s_r        = {32'h1234_5678, 2'b10, 1'b0, 4'h3};
        m0_rready  = 1'b1;
        pl1        = mk_ar(0);
        m1_ar      = pl1;
        m1_arvalid = 1'b1;
        #1;
        chk("pre_rst_rvalid", 64'(m0_rvalid), 64'(1));
        chk("pre_rst_resp", 64'(m0_r), 64'({32'h1234_5678, 2'b10, 1'b0, 4'h3}));
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_rready", 64'(s_rready), 64'(0));
        chk("midrst_arready", 64'({m0_arready, m1_arready}), 64'(0));
        chk("midrst_rvalid", 64'(m0_rvalid), 64'(0));
        s_rvalid  = 1'b0;
        s_r       = '0;
        m0_rready = 1'b0;
        step();
        reset = 1'b0;
        pend0 = 0;
        pend1 = 1;
        mcnt  = 0;
        txn(0, 0, 0, 0, 2, -2, 0);
        txn(1, 1, 2, 1, 1, 2, 1);
        txn(0, 0, 0, 0, 0, -2, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
